// File: rtl/aurora_pkt_pkg.sv
// Shared packet-framing definitions for the Aurora RX parser and TX packetizer.
// Provides FSM state encoding, completion error codes, the default header
// magic, header field positions and a header unpack helper.
package aurora_pkt_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hBE11;

  // Header word layout: magic in the upper half, payload length in the lower.
  localparam int unsigned HDR_MAGIC_MSB = 31;
  localparam int unsigned HDR_MAGIC_LSB = 16;
  localparam int unsigned HDR_LEN_MSB   = 15;
  localparam int unsigned HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2
  } pkt_state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] len;
  } pkt_hdr_t;

  // Split a raw FIFO word into header fields.
  function automatic pkt_hdr_t hdr_unpack(input logic [DATA_W-1:0] word);
    pkt_hdr_t h;
    h.magic = word[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    h.len   = word[HDR_LEN_MSB:HDR_LEN_LSB];
    return h;
  endfunction

  // Legal payload length is 1..max_len words.
  function automatic logic hdr_len_ok(input logic [15:0] len, input int unsigned max_len);
    return (len != 16'h0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/aurora_rx_pkt_parser_if.sv
// Bus bundle between the RX FIFO read side, the parser and the DSP consumer.
// master: the parser (drives fifo_rd_o, payload stream and status).
// slave:  the environment (drives FIFO head/empty and consumer ready).
interface aurora_rx_pkt_parser_if;
  import aurora_pkt_pkg::*;

  logic [DATA_W-1:0] fifo_dat_i;
  logic              fifo_empty_i;
  logic              fifo_rd_o;
  logic [DATA_W-1:0] pkt_dat_o;
  logic              pkt_vld_o;
  logic              pkt_rdy_i;
  logic              pkt_sof_o;
  logic              pkt_eof_o;
  logic              pkt_done_o;
  logic              pkt_ok_o;
  logic [1:0]        err_code_o;
  logic [CNT_W-1:0]  good_cnt_o;
  logic [CNT_W-1:0]  bad_cnt_o;

  modport master (
    input  fifo_dat_i, fifo_empty_i, pkt_rdy_i,
    output fifo_rd_o, pkt_dat_o, pkt_vld_o, pkt_sof_o, pkt_eof_o,
           pkt_done_o, pkt_ok_o, err_code_o, good_cnt_o, bad_cnt_o
  );

  modport slave (
    output fifo_dat_i, fifo_empty_i, pkt_rdy_i,
    input  fifo_rd_o, pkt_dat_o, pkt_vld_o, pkt_sof_o, pkt_eof_o,
           pkt_done_o, pkt_ok_o, err_code_o, good_cnt_o, bad_cnt_o
  );
endinterface

// File: rtl/aurora_rx_pkt_parser_sat_cnt16.sv
// Enable-driven 16-bit counter that sticks at all-ones.
// Ports: clk, rst_n (async active-low), en (count this cycle), count (value).
module sat_cnt16
  import aurora_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aurora_rx_pkt_parser.sv
// Aurora RX packet parser: drains the RX FIFO, finds headers, forwards the
// payload cut-through to the consumer, verifies the trailer checksum and
// reports per-packet status plus saturating good/bad counters.
// Ports: user_clk, rst_n (async active-low), channel_up, flush,
//        bus (master modport: FIFO read side, payload stream, status).
module aurora_rx_pkt_parser
  import aurora_pkt_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter int unsigned MAX_LEN   = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                   user_clk,
  input  logic                   rst_n,
  input  logic                   channel_up,
  input  logic                   flush,
  aurora_rx_pkt_parser_if.master bus
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  pkt_state_e        state, state_nxt;
  logic [15:0]       len_q, remaining_q;
  logic [DATA_W-1:0] sum_q;
  logic [IDLE_W-1:0] idle_q;
  logic              done_q, ok_q;
  logic [1:0]        err_q;

  pkt_hdr_t hdr;
  logic     abort_req;
  logic     tmo_hit;
  logic     csum_match;

  // Combinational FSM outputs and event strobes.
  logic rd_c, vld_c, sof_c, eof_c;
  logic hdr_take, hdr_bad, beat, trl_pop, tmo_ev, abort_ev;
  logic good_en, bad_en;

  assign hdr        = hdr_unpack(bus.fifo_dat_i);
  assign abort_req  = flush || !channel_up;
  assign tmo_hit    = bus.fifo_empty_i && (idle_q == IDLE_W'(TIMEOUT - 1));
  assign csum_match = (bus.fifo_dat_i == sum_q);

  // State register.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and zero-latency FIFO/stream handshake; everything is held
  // low while rst_n is asserted so nothing pops or streams during reset.
  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    vld_c     = 1'b0;
    sof_c     = 1'b0;
    eof_c     = 1'b0;
    hdr_take  = 1'b0;
    hdr_bad   = 1'b0;
    beat      = 1'b0;
    trl_pop   = 1'b0;
    tmo_ev    = 1'b0;
    abort_ev  = 1'b0;

    if (rst_n) begin
      unique case (state)
        ST_HUNT: begin
          if (!abort_req && !bus.fifo_empty_i) begin
            rd_c = 1'b1;
            if (hdr.magic == HDR_MAGIC) begin
              if (hdr_len_ok(hdr.len, MAX_LEN)) begin
                hdr_take  = 1'b1;
                state_nxt = ST_PAYLOAD;
              end else begin
                hdr_bad = 1'b1;
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (abort_req) begin
            abort_ev  = 1'b1;
            state_nxt = ST_HUNT;
          end else if (tmo_hit) begin
            tmo_ev    = 1'b1;
            state_nxt = ST_HUNT;
          end else begin
            vld_c = !bus.fifo_empty_i;
            sof_c = vld_c && (remaining_q == len_q);
            eof_c = vld_c && (remaining_q == 16'd1);
            rd_c  = vld_c && bus.pkt_rdy_i;
            beat  = rd_c;
            if (beat && (remaining_q == 16'd1)) begin
              state_nxt = ST_TRAILER;
            end
          end
        end

        ST_TRAILER: begin
          if (abort_req) begin
            abort_ev  = 1'b1;
            state_nxt = ST_HUNT;
          end else if (tmo_hit) begin
            tmo_ev    = 1'b1;
            state_nxt = ST_HUNT;
          end else if (!bus.fifo_empty_i) begin
            rd_c      = 1'b1;
            trl_pop   = 1'b1;
            state_nxt = ST_HUNT;
          end
        end

        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  // Length tracking and running checksum.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
    end else if (hdr_take) begin
      len_q       <= hdr.len;
      remaining_q <= hdr.len;
      sum_q       <= '0;
    end else if (beat) begin
      remaining_q <= remaining_q - 16'd1;
      sum_q       <= sum_q + bus.fifo_dat_i;
    end
  end

  // Idle counter: counts empty cycles mid-packet, holds under backpressure,
  // clears on any pop and whenever the packet ends.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (rd_c || (state_nxt == ST_HUNT)) begin
      idle_q <= '0;
    end else if (bus.fifo_empty_i) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  // Packet completion status, valid for one cycle with done.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= ERR_OK;
    end else begin
      done_q <= trl_pop || tmo_ev || abort_ev;
      ok_q   <= trl_pop && csum_match;
      if (abort_ev) begin
        err_q <= ERR_ABORT;
      end else if (tmo_ev) begin
        err_q <= ERR_TIMEOUT;
      end else if (trl_pop && !csum_match) begin
        err_q <= ERR_CSUM;
      end else begin
        err_q <= ERR_OK;
      end
    end
  end

  assign good_en = trl_pop && csum_match;
  assign bad_en  = hdr_bad || (trl_pop && !csum_match) || tmo_ev || abort_ev;

  sat_cnt16 u_good_cnt (
    .clk   (user_clk),
    .rst_n (rst_n),
    .en    (good_en),
    .count (bus.good_cnt_o)
  );

  sat_cnt16 u_bad_cnt (
    .clk   (user_clk),
    .rst_n (rst_n),
    .en    (bad_en),
    .count (bus.bad_cnt_o)
  );

  assign bus.fifo_rd_o  = rd_c;
  assign bus.pkt_vld_o  = vld_c;
  assign bus.pkt_dat_o  = vld_c ? bus.fifo_dat_i : '0;
  assign bus.pkt_sof_o  = sof_c;
  assign bus.pkt_eof_o  = eof_c;
  assign bus.pkt_done_o = done_q;
  assign bus.pkt_ok_o   = ok_q;
  assign bus.err_code_o = err_q;

endmodule

// File: tb/tb_aurora_rx_pkt_parser.sv
// Directed self-checking bench for aurora_rx_pkt_parser with an FWFT FIFO
// model feeding the parser and a negedge monitor capturing stream/status.
module tb_aurora_rx_pkt_parser;
  import aurora_pkt_pkg::*;

  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXL = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic channel_up;
  logic flush;

  aurora_rx_pkt_parser_if bus ();

  aurora_rx_pkt_parser #(
    .HDR_MAGIC (16'hBE11),
    .MAX_LEN   (MAXL),
    .TIMEOUT   (TMO)
  ) dut (
    .user_clk   (clk),
    .rst_n      (rst_n),
    .channel_up (channel_up),
    .flush      (flush),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model.
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [5:0]  rd_idx;

  assign rd_idx           = rd_ptr[5:0];
  assign bus.fifo_empty_i = (rd_ptr == wr_ptr);
  assign bus.fifo_dat_i   = (rd_ptr == wr_ptr) ? 32'h0 : mem[rd_idx];

  always @(posedge clk) begin
    if (bus.fifo_rd_o) rd_ptr <= rd_ptr + 1;
  end

  // Monitor.
  logic [31:0] b_dat [0:15];
  logic        b_sof [0:15];
  logic        b_eof [0:15];
  int          nb = 0, nd = 0, neof = 0, nviol = 0;
  logic        d_ok;
  logic [1:0]  d_err;

  always @(negedge clk) begin
    if (bus.pkt_vld_o && bus.pkt_rdy_i) begin
      if (nb < 16) begin
        b_dat[nb] = bus.pkt_dat_o;
        b_sof[nb] = bus.pkt_sof_o;
        b_eof[nb] = bus.pkt_eof_o;
      end
      nb++;
      if (bus.pkt_eof_o) neof++;
    end
    if (bus.fifo_rd_o && bus.fifo_empty_i) nviol++;
    if (bus.fifo_rd_o && bus.pkt_vld_o && !bus.pkt_rdy_i) nviol++;
    if (!bus.pkt_done_o && (bus.pkt_ok_o || (bus.err_code_o != 2'd0))) nviol++;
    if (bus.pkt_done_o) begin
      d_ok  = bus.pkt_ok_o;
      d_err = bus.err_code_o;
      nd++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    logic [5:0] idx;
    idx      = wr_ptr[5:0];
    mem[idx] = w;
    wr_ptr++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag, input int extra);
    int n;
    n = 0;
    while ((rd_ptr != wr_ptr) && (n < 200)) begin
      step(1);
      n++;
    end
    check(tag, 32'(rd_ptr == wr_ptr), 32'd1);
    step(extra);
  endtask

  task automatic clr();
    nb   = 0;
    nd   = 0;
    neof = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n         = 1'b0;
    channel_up    = 1'b1;
    flush         = 1'b0;
    bus.pkt_rdy_i = 1'b1;

    // Reset: a queued word must not be popped, all outputs low.
    push(32'hDEADBEEF);
    step(3);
    check("rst_rd", 32'(bus.fifo_rd_o), 32'd0);
    check("rst_vld", 32'(bus.pkt_vld_o), 32'd0);
    check("rst_done", 32'(bus.pkt_done_o), 32'd0);
    check("rst_good", 32'(bus.good_cnt_o), 32'd0);
    check("rst_bad", 32'(bus.bad_cnt_o), 32'd0);
    rst_n = 1'b1;
    drain("drain0", 2);
    check("garbage_nocount", 32'(bus.bad_cnt_o), 32'd0);
    clr();

    // Good 3-word packet.
    push(32'hBE110003); push(32'd1); push(32'd2); push(32'd3); push(32'd6);
    drain("drain1", 3);
    check("t1_beats", 32'(nb), 32'd3);
    check("t1_b0", b_dat[0], 32'd1);
    check("t1_b0_sof", 32'(b_sof[0]), 32'd1);
    check("t1_b0_eof", 32'(b_eof[0]), 32'd0);
    check("t1_b1_sofeof", 32'({b_sof[1], b_eof[1]}), 32'd0);
    check("t1_b2", b_dat[2], 32'd3);
    check("t1_b2_eof", 32'({b_sof[2], b_eof[2]}), 32'd1);
    check("t1_done", 32'(nd), 32'd1);
    check("t1_ok", 32'(d_ok), 32'd1);
    check("t1_err", 32'(d_err), 32'd0);
    check("t1_good", 32'(bus.good_cnt_o), 32'd1);
    check("t1_bad", 32'(bus.bad_cnt_o), 32'd0);
    clr();

    // Checksum error.
    push(32'hBE110003); push(32'd1); push(32'd2); push(32'd3); push(32'd7);
    drain("drain2", 3);
    check("t2_beats", 32'(nb), 32'd3);
    check("t2_done", 32'(nd), 32'd1);
    check("t2_ok", 32'(d_ok), 32'd0);
    check("t2_err", 32'(d_err), 32'd1);
    check("t2_bad", 32'(bus.bad_cnt_o), 32'd1);
    check("t2_good", 32'(bus.good_cnt_o), 32'd1);
    clr();

    // Garbage, zero-length and oversize headers, then a len-1 packet.
    push(32'h12345678); push(32'hBE110000); push(32'hBE110009);
    push(32'hBE110001); push(32'hAAAA5555); push(32'hAAAA5555);
    drain("drain3", 3);
    check("t3_beats", 32'(nb), 32'd1);
    check("t3_dat", b_dat[0], 32'hAAAA5555);
    check("t3_sofeof", 32'({b_sof[0], b_eof[0]}), 32'd3);
    check("t3_ok", 32'(d_ok), 32'd1);
    check("t3_bad", 32'(bus.bad_cnt_o), 32'd3);
    check("t3_good", 32'(bus.good_cnt_o), 32'd2);
    clr();

    // Toggling ready across a 4-word payload with checksum wrap.
    push(32'hBE110004); push(32'hFFFFFFFF); push(32'd2); push(32'h1E); push(32'h28);
    push(32'h47);
    for (int i = 0; i < 30; i++) begin
      bus.pkt_rdy_i = (i % 2) == 0;
      step(1);
    end
    bus.pkt_rdy_i = 1'b1;
    drain("drain4", 3);
    check("t4_beats", 32'(nb), 32'd4);
    check("t4_b0", b_dat[0], 32'hFFFFFFFF);
    check("t4_b1", b_dat[1], 32'd2);
    check("t4_b2", b_dat[2], 32'h1E);
    check("t4_b3", b_dat[3], 32'h28);
    check("t4_done", 32'(nd), 32'd1);
    check("t4_err", 32'(d_err), 32'd0);
    check("t4_good", 32'(bus.good_cnt_o), 32'd3);
    check("t4_viol", 32'(nviol), 32'd0);
    clr();

    // Timeout: 2 of 5 words then starvation.
    push(32'hBE110005); push(32'd1); push(32'd2);
    cnt = 0;
    @(negedge clk);
    while ((rd_ptr != wr_ptr) && (cnt < 50)) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 1;
    while (!bus.pkt_done_o && (cnt < int'(TMO) + 10)) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_latency", 32'(cnt), 32'(TMO + 1));
    step(2);
    check("t5_done", 32'(nd), 32'd1);
    check("t5_err", 32'(d_err), 32'd2);
    check("t5_noeof", 32'(neof), 32'd0);
    check("t5_bad", 32'(bus.bad_cnt_o), 32'd4);
    clr();

    // Backpressure longer than TIMEOUT, then channel drop mid-payload.
    push(32'hBE110004); push(32'd1); push(32'd2);
    drain("drain6", 2);
    bus.pkt_rdy_i = 1'b0;
    push(32'd3);
    step(TMO + 4);
    check("t6_bp_vld", 32'(bus.pkt_vld_o), 32'd1);
    check("t6_bp_nodone", 32'(nd), 32'd0);
    channel_up = 1'b0;
    #1;
    check("t6_abort_vld", 32'(bus.pkt_vld_o), 32'd0);
    check("t6_abort_rd", 32'(bus.fifo_rd_o), 32'd0);
    step(1);
    channel_up    = 1'b1;
    bus.pkt_rdy_i = 1'b1;
    drain("drain6b", 3);
    check("t6_done", 32'(nd), 32'd1);
    check("t6_err", 32'(d_err), 32'd3);
    check("t6_ok", 32'(d_ok), 32'd0);
    check("t6_noeof", 32'(neof), 32'd0);
    check("t6_bad", 32'(bus.bad_cnt_o), 32'd5);
    clr();

    // Flush held in HUNT blocks popping.
    flush = 1'b1;
    push(32'hBE110001);
    step(3);
    check("t7_flush_hold", 32'(wr_ptr - rd_ptr), 32'd1);
    flush = 1'b0;
    push(32'h77); push(32'h77);
    drain("drain7", 3);
    check("t7_good", 32'(bus.good_cnt_o), 32'd4);
    clr();

    // Reset mid-payload clears everything immediately.
    push(32'hBE110003); push(32'd5); push(32'd6);
    drain("drain8", 1);
    bus.pkt_rdy_i = 1'b0;
    push(32'd7);
    #1;
    check("t8_pre_vld", 32'(bus.pkt_vld_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_vld", 32'(bus.pkt_vld_o), 32'd0);
    check("t8_eof", 32'(bus.pkt_eof_o), 32'd0);
    check("t8_rd", 32'(bus.fifo_rd_o), 32'd0);
    check("t8_good", 32'(bus.good_cnt_o), 32'd0);
    check("t8_bad", 32'(bus.bad_cnt_o), 32'd0);
    step(1);
    rst_n         = 1'b1;
    bus.pkt_rdy_i = 1'b1;
    drain("drain8b", 2);
    clr();
    push(32'hBE110001); push(32'd9); push(32'd9);
    drain("drain9", 3);
    check("t9_beats", 32'(nb), 32'd1);
    check("t9_good", 32'(bus.good_cnt_o), 32'd1);
    check("t9_bad", 32'(bus.bad_cnt_o), 32'd0);
    check("final_viol", 32'(nviol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aurora_rx_pkt_parser.md
Name: aurora_rx_pkt_parser

Overview:
Sits directly downstream of the Aurora unit's RX write FIFO and drains it from the FIFO's read side. It delineates framed packets (header, payload, trailer), checks length and checksum, and forwards payload cut-through to the DSP-side consumer on a valid/ready stream. It reports per-packet good/bad status and keeps error counters, so garbage left in the channel after reset is discarded instead of reaching the consumer.

Parameters:
HDR_MAGIC, 16'hBE11, required value of header word bits [31:16]
MAX_LEN, 1024, largest legal payload length in words (1..65535)
TIMEOUT, 4096, idle cycles allowed mid-packet before abort (>=2)

Ports:
user_clk  in  1  Aurora user clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
channel_up  in  1  Aurora channel status, synchronous to user_clk
flush  in  1  synchronous abort-and-resync request (one-cycle pulse or level)
fifo_dat_i  in  32  FWFT FIFO head word, valid when fifo_empty_i=0
fifo_empty_i  in  1  FIFO empty
fifo_rd_o  out  1  pop FIFO head this cycle
pkt_dat_o  out  32  payload word
pkt_vld_o  out  1  payload word valid
pkt_rdy_i  in  1  consumer ready
pkt_sof_o  out  1  first payload word (qualified by vld)
pkt_eof_o  out  1  last payload word (qualified by vld)
pkt_done_o  out  1  one-cycle pulse, packet finished (trailer consumed or aborted)
pkt_ok_o  out  1  with pkt_done_o: packet good
err_code_o  out  2  with pkt_done_o: 0 ok, 1 checksum, 2 timeout, 3 abort (flush/channel drop)
good_cnt_o  out  16  good packets, saturating
bad_cnt_o  out  16  bad/aborted packets plus bad headers, saturating

Behaviour:
- Reset (rst_n=0, async): state HUNT; every output 0; counters 0; checksum and length registers 0.
- FWFT semantics: a word transfers when fifo_rd_o=1, and fifo_rd_o is never asserted while fifo_empty_i=1.
- HUNT: fifo_rd_o = !fifo_empty_i (one word popped per cycle). A word with [31:16]==HDR_MAGIC and 1<=[15:0]<=MAX_LEN latches len=[15:0], clears the running sum and moves to PAYLOAD. A magic match with an illegal length, or any non-matching word, is discarded; a bad-length header also increments bad_cnt_o. No pkt_done_o is raised in HUNT.
- PAYLOAD: combinational pass-through with zero latency. pkt_dat_o=fifo_dat_i; pkt_vld_o=!fifo_empty_i; fifo_rd_o=pkt_vld_o&pkt_rdy_i. On each transfer: sum<=sum+word (mod 2^32) and remaining<=remaining-1. sof is asserted on the first word; eof when remaining==1. After the eof transfer, move to TRAILER. When len==1, sof and eof are asserted together.
- TRAILER: fifo_rd_o=!fifo_empty_i. On pop, compare the word to sum. Equal gives pkt_done_o=1, pkt_ok_o=1, err 0, and good_cnt_o increments; unequal gives err 1 and bad_cnt_o increments. Then move to HUNT.
- Timeout: an idle counter runs in PAYLOAD/TRAILER while fifo_empty_i=1 and clears on any pop. Consumer backpressure (fifo not empty, rdy=0) does not count. When the counter reaches TIMEOUT, raise pkt_done_o with err 2, increment bad_cnt_o and go to HUNT.
- Abort: flush=1 or channel_up=0 in PAYLOAD/TRAILER gives pkt_done_o with err 3, increment bad_cnt_o, go to HUNT. In that cycle fifo_rd_o=0 and pkt_vld_o=0. In HUNT, flush or channel_up=0 holds HUNT with fifo_rd_o=0.
- An aborted or timed-out packet never shows eof downstream. The consumer must drop partial data on pkt_done_o with pkt_ok_o=0.
- Priority (highest first): rst_n, abort, timeout, normal transfer.
- Counters stick at 16'hFFFF. pkt_ok_o and err_code_o are 0 whenever pkt_done_o=0.

Decomposition:
- Shared package aurora_pkt_pkg: state encoding (HUNT, PAYLOAD, TRAILER), err code constants, default HDR_MAGIC, and header field positions [31:16]/[15:0]. The TX-side packetizer uses the same package.
- One natural sub-module: sat_cnt16 (enable, saturating 16-bit counter), instantiated twice.

Test Plan:
- Header 0xBE110003, payload 1,2,3, trailer 6, rdy always 1 -> three vld beats (sof on 1, eof on 3), then pkt_done/ok=1 and good_cnt=1.
- Same packet with trailer 7 -> payload forwarded, then pkt_done with ok=0, err=1, bad_cnt=1.
- Garbage 0x12345678, 0xBE110000, then a valid len-1 packet -> the first two words are dropped with bad_cnt=1, then the packet is forwarded with sof=eof=1.
- pkt_rdy_i toggling 1010 across a 4-word payload -> no word lost or duplicated, fifo_rd_o only when rdy=1, and no timeout while the FIFO is non-empty.
- Header len=5, 2 words, then FIFO empty for TIMEOUT cycles -> pkt_done with err=2 at cycle TIMEOUT, then state HUNT.
- channel_up dropped mid-payload, and separately rst_n asserted mid-payload -> err=3 pulse with bad_cnt incremented in the first case; all outputs and counters 0 immediately in the second.
